// File: rtl/serial_route_engine_if.sv
// Bundles the load/configure/execute controls and the result/status signals
// of the serial route engine. The master side drives controls, the slave
// side (the engine) drives register contents and status.
interface serial_route_engine_if #(
    parameter int WIDTH = 8
);
    logic             LoadA;
    logic             LoadB;
    logic [WIDTH-1:0] Din;
    logic [2:0]       F;
    logic [1:0]       R;
    logic             Execute;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Busy;
    logic             Done;

    modport master (
        output LoadA, LoadB, Din, F, R, Execute,
        input  Aval, Bval, Busy, Done
    );

    modport slave (
        input  LoadA, LoadB, Din, F, R, Execute,
        output Aval, Bval, Busy, Done
    );
endinterface

// File: rtl/serial_route_engine.sv
// Serial logic processor: two WIDTH-bit operand registers shifted right WIDTH
// times per run. Each shift computes a bitwise function of the two LSBs and a
// 4-way router picks the bit fed into the MSB of each register.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | accepts loads; Execute latches F/R, clears cnt and starts a run
// S_SHIFT | one shift per cycle, WIDTH shifts total; all inputs ignored
// S_HOLD  | result frozen; waits for Execute low before returning to idle
module serial_route_engine #(
    parameter int WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    serial_route_engine_if.slave  bus
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_f;
    logic [1:0]       r_r;
    logic [CNT_W-1:0] r_cnt;

    logic             w_a0;
    logic             w_b0;
    logic             w_fab;
    logic             w_a_new;
    logic             w_b_new;
    logic             w_last;

    assign w_a0   = r_a[0];
    assign w_b0   = r_b[0];
    assign w_last = (r_cnt == CNT_LAST);

    // State register; reset aborts any run in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode. HOLD needs Execute low once so a held request
    // cannot retrigger a run.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.Execute) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.Execute) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bit function of the two LSBs, selected by the latched op code.
    always_comb begin
        w_fab = 1'b0;
        case (r_f)
            3'b000:  w_fab = w_a0 & w_b0;
            3'b001:  w_fab = w_a0 | w_b0;
            3'b010:  w_fab = w_a0 ^ w_b0;
            3'b011:  w_fab = 1'b1;
            3'b100:  w_fab = ~(w_a0 & w_b0);
            3'b101:  w_fab = ~(w_a0 | w_b0);
            3'b110:  w_fab = ~(w_a0 ^ w_b0);
            default: w_fab = 1'b0;
        endcase
    end

    // Router: chooses the bit that enters the MSB of each register.
    always_comb begin
        w_a_new = w_a0;
        w_b_new = w_b0;
        case (r_r)
            2'b00: begin
                w_a_new = w_a0;
                w_b_new = w_b0;
            end
            2'b01: begin
                w_a_new = w_a0;
                w_b_new = w_fab;
            end
            2'b10: begin
                w_a_new = w_fab;
                w_b_new = w_b0;
            end
            default: begin
                w_a_new = w_b0;
                w_b_new = w_a0;
            end
        endcase
    end

    // Operand, configuration and counter registers. Loads act only in idle;
    // the counter parks at WIDTH-1 after the final shift.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_f   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.LoadA) begin
                        r_a <= bus.Din;
                    end
                    if (bus.LoadB) begin
                        r_b <= bus.Din;
                    end
                    if (bus.Execute) begin
                        r_f   <= bus.F;
                        r_r   <= bus.R;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a <= {w_a_new, r_a[WIDTH-1:1]};
                    r_b <= {w_b_new, r_b[WIDTH-1:1]};
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and result outputs straight from registered state.
    always_comb begin
        bus.Aval = r_a;
        bus.Bval = r_b;
        bus.Busy = (r_state == S_SHIFT);
        bus.Done = (r_state == S_HOLD);
    end

endmodule

// File: doc/serial_route_engine.md
Name: serial_route_engine

Overview:
Parametrised serial logic processor datapath and controller. It holds two WIDTH-bit operand registers, A and B. On each Execute it shifts both registers right WIDTH times. Each cycle a bitwise function of the two LSBs is computed, and a 4-way router selects the new MSB of each register. It extends the fixed 2-bit-select routing stage with its own operand storage, a latched op/route configuration, a bit counter and a run/hold control FSM.

Parameters:
WIDTH, 8, operand register width in bits; legal range 2..32.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
LoadA  input  1  loads Din into A (IDLE only).
LoadB  input  1  loads Din into B (IDLE only).
Din  input  WIDTH  parallel load data.
F  input  3  bit function select, sampled at run start.
R  input  2  route select, sampled at run start.
Execute  input  1  run request, level-sensitive with a release requirement.
Aval  output  WIDTH  current contents of register A.
Bval  output  WIDTH  current contents of register B.
Busy  output  1  high while shifting.
Done  output  1  high while the result is held after a run.

Behaviour:
Reset (asynchronous, active-high):
- A=0, B=0, f_q=0, r_q=0, cnt=0, state=IDLE.
- Outputs: Aval=0, Bval=0, Busy=0, Done=0.
- A Reset during SHIFT aborts the run immediately; the partial result is discarded (registers are zeroed).

FSM states are IDLE, SHIFT and HOLD.

IDLE:
- LoadA=1 loads A<=Din. LoadB=1 loads B<=Din. Both high loads both.
- If Execute=1: f_q<=F, r_q<=R, cnt<=0, next state SHIFT. No shift happens on this edge.
- If Execute=1 and a load are high on the same edge, the load is performed and the run starts with the loaded values.

SHIFT:
- Each edge, with a0=A[0] and b0=B[0]:
  - fab = func(f_q, a0, b0).
  - A <= {a_new, A[WIDTH-1:1]} and B <= {b_new, B[WIDTH-1:1]}.
  - cnt <= cnt+1.
- When cnt==WIDTH-1, perform the final shift and go to HOLD. This gives exactly WIDTH shifts, with Busy high for exactly WIDTH cycles.
- LoadA, LoadB, F and R are ignored in this state. Execute is ignored in this state, including deassertion.

HOLD:
- Registers are frozen. Loads are ignored.
- Stay while Execute=1. Go to IDLE on the first edge that samples Execute=0.
- Consequence: holding Execute high never retriggers a run. Execute must drop for at least one cycle before the next run.

func(f_q, a, b):
- 000 a&b
- 001 a|b
- 010 a^b
- 011 1
- 100 ~(a&b)
- 101 ~(a|b)
- 110 ~(a^b)
- 111 0

Route select r_q (a_new, b_new):
- 00: (a0, b0), rotate both.
- 01: (a0, fab).
- 10: (fab, b0).
- 11: (b0, a0), swap.

Arithmetic and widths:
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.

Outputs:
- Aval and Bval are direct register outputs.
- Busy = (state==SHIFT). Done = (state==HOLD). Both are registered-state decodes with no combinational input path.

Test Plan:
- WIDTH=8; load A=0x33, B=0x55; F=000, R=10; pulse Execute then release -> Busy high 8 cycles; then A=0x11, B=0x55 and Done=1 until Execute is observed low.
- Same loads; F=010, R=01 -> A=0x33, B=0x66. Then F=xxx, R=11 -> A=0x55, B=0x33 (swap). Then R=00 -> values unchanged.
- F=011, R=10 with A=0x00 -> A=0xFF. F=111, R=01 with B=0xFF -> B=0x00.
- Hold Execute high for 20 cycles -> exactly one 8-cycle run and Done high until release. Release 1 cycle and reassert -> second run executes.
- Toggle LoadA/LoadB with Din=0xAA, and change F/R, during SHIFT and HOLD -> no effect on the result. A load on the same edge as Execute in IDLE -> the run uses the loaded value.
- Assert Reset asynchronously at shift 4 -> Aval=Bval=0 and Busy=Done=0 immediately. After release the FSM is in IDLE and a new run completes correctly. Repeat the first scenario with WIDTH=4 (A=0x3, B=0x5 -> A=0x1).
